// File: rtl/spi_rx_pkg.sv
// Shared types and widths for the SPI slave receiver.
package spi_rx_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned BIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_WAIT_HI = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Multi-stage synchronizer for an asynchronous input, followed by an edge-detect flop.
module spi_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver: assembles MSB-first bytes into a one-entry valid/ready
// holding register and flags overrun and mid-byte frame termination.
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  sdi,
    input  logic                  rx_rdy,
    input  logic                  clr,
    output logic [SPI_BYTE_W-1:0] rx_dat,
    output logic                  rx_vld,
    output logic                  frm_end,
    output logic [CNT_W-1:0]      frm_cnt,
    output logic                  ovr,
    output logic                  frm_err,
    output logic                  busy
);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;

    spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sclk), .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );
    spi_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .rst(rst), .d(sdi), .lvl(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
    );

    // Only the data level is needed; sclk level and data edges are unused here.
    logic unused_sync_sigs;
    assign unused_sync_sigs = sck_lvl ^ sck_fall ^ sdi_rise ^ sdi_fall;

    state_t                 state, state_nxt;
    logic [SPI_BYTE_W-2:0]  shift_q, shift_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [SPI_BYTE_W-1:0]  rx_dat_nxt;
    logic                   rx_vld_nxt, frm_end_nxt, ovr_nxt, frm_err_nxt;
    logic [CNT_W-1:0]       frm_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_WAIT_HI;
            shift_q <= '0;
            bit_cnt <= '0;
            rx_dat  <= '0;
            rx_vld  <= 1'b0;
            frm_end <= 1'b0;
            frm_cnt <= '0;
            ovr     <= 1'b0;
            frm_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            rx_dat  <= rx_dat_nxt;
            rx_vld  <= rx_vld_nxt;
            frm_end <= frm_end_nxt;
            frm_cnt <= frm_cnt_nxt;
            ovr     <= ovr_nxt;
            frm_err <= frm_err_nxt;
            busy    <= (state_nxt == ST_SHIFT);
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        rx_dat_nxt  = rx_dat;
        rx_vld_nxt  = rx_vld & ~rx_rdy;
        frm_end_nxt = 1'b0;
        frm_cnt_nxt = frm_cnt;
        ovr_nxt     = ovr & ~clr;
        frm_err_nxt = frm_err & ~clr;

        unique case (state)
            ST_WAIT_HI: begin
                if (ss_lvl) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    state_nxt   = ST_SHIFT;
                    bit_cnt_nxt = '0;
                    frm_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                // ss_rise takes priority over a coincident sclk edge.
                if (ss_rise) begin
                    state_nxt   = ST_IDLE;
                    frm_end_nxt = 1'b1;
                    bit_cnt_nxt = '0;
                    if (bit_cnt != '0) frm_err_nxt = 1'b1;
                end else if (sck_rise) begin
                    shift_nxt   = {shift_q[SPI_BYTE_W-3:0], sdi_lvl};
                    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == '1) begin
                        if (frm_cnt != '1) frm_cnt_nxt = frm_cnt + CNT_W'(1);
                        if (!rx_vld || rx_rdy) begin
                            rx_dat_nxt = {shift_q, sdi_lvl};
                            rx_vld_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ST_WAIT_HI;
        endcase
    end

endmodule

// File: tb/tb_spi_rx.sv
// Randomized self-checking bench for spi_rx against a byte-level behavioural model.
module tb_spi_rx;

    logic       clk = 1'b0;
    logic       rst, sclk, ss, sdi, rx_rdy, clr;
    logic [7:0] rx_dat;
    logic       rx_vld, frm_end, ovr, frm_err, busy;
    logic [7:0] frm_cnt;

    spi_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .sdi(sdi), .rx_rdy(rx_rdy), .clr(clr),
        .rx_dat(rx_dat), .rx_vld(rx_vld), .frm_end(frm_end), .frm_cnt(frm_cnt),
        .ovr(ovr), .frm_err(frm_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;

    // Model state: bytes the consumer must see in order, and the expected flag/holding values.
    logic [7:0] exp_q[$];
    logic       m_pending = 1'b0;
    logic [7:0] m_held    = 8'h00;
    logic       m_ovr     = 1'b0;
    logic       m_frm_err = 1'b0;
    int         m_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer-side scoreboard and frame-end pulse counter.
    always @(negedge clk) begin
        if (!rst && rx_vld && rx_rdy) begin
            if (exp_q.size() == 0) check("xfer_expected", 32'(0), 32'(1));
            else check("xfer_dat", 32'(rx_dat), 32'(exp_q.pop_front()));
        end
        if (frm_end) fe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_ovr = 1'b0; m_frm_err = 1'b0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        if (rx_rdy) exp_q.push_back(b);
        else if (!m_pending) begin
            exp_q.push_back(b); m_pending = 1'b1; m_held = b;
        end else m_ovr = 1'b1;
    endtask

    task automatic set_rdy(input logic v);
        rx_rdy = v;
        if (v) begin
            repeat (3) tick();
            m_pending = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0; tick();
        m_ovr = 1'b0; m_frm_err = 1'b0;
    endtask

    // Master side at clk/2: data changes with sclk low, sampled on sclk rise.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit pulse_rdy);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0; sdi = b[3'(7 - i)]; tick();
            sclk = 1'b1;
            if (pulse_rdy && i == nbits - 1) begin
                tick(); tick(); rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
            end else tick();
        end
    endtask

    task automatic frame_start();
        sclk = 1'b0; ss = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_stop();
        sclk = 1'b0; tick(); tick();
        ss = 1'b1;
        repeat (6) tick();
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".frm_cnt"}, 32'(frm_cnt), 32'(m_cnt));
        check({tag, ".ovr"}, 32'(ovr), 32'(m_ovr));
        check({tag, ".frm_err"}, 32'(frm_err), 32'(m_frm_err));
        check({tag, ".rx_vld"}, 32'(rx_vld), 32'(m_pending));
        if (m_pending) check({tag, ".rx_dat"}, 32'(rx_dat), 32'(m_held));
        check({tag, ".busy"}, 32'(busy), 32'(0));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] bytes[$], input int partial);
        int fe0;
        fe0 = fe_cnt;
        frame_start();
        @(negedge clk);
        check({tag, ".busy_mid"}, 32'(busy), 32'(1));
        m_cnt = 0;
        foreach (bytes[i]) begin
            send_bits(bytes[i], 8, 1'b0);
            model_byte(bytes[i]);
        end
        if (partial > 0) begin
            send_bits(8'($urandom), partial, 1'b0);
            m_frm_err = 1'b1;
        end
        frame_stop();
        check({tag, ".frm_end"}, 32'(fe_cnt - fe0), 32'(1));
        check_state(tag);
    endtask

    initial begin
        logic [7:0] q[$];
        int fe0;
        rst = 1'b1; sclk = 1'b0; ss = 1'b1; sdi = 1'b0; rx_rdy = 1'b0; clr = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst.outs", 32'({rx_dat, rx_vld, frm_end, frm_cnt, ovr, frm_err, busy}), 32'(0));
        rst = 1'b0;
        repeat (5) tick();
        check_state("rst");

        // Single byte into an empty holding register.
        q = {8'hA5};
        run_frame("t1", q, 0);
        set_rdy(1'b1);

        // Three bytes with the consumer always ready.
        q = {8'h01, 8'h80, 8'hFF};
        run_frame("t2", q, 0);

        // Consume the held byte in the same cycle the next byte completes.
        set_rdy(1'b0);
        q = {8'h77};
        run_frame("t2b.a", q, 0);
        frame_start();
        m_cnt = 0;
        send_bits(8'h99, 8, 1'b1);
        exp_q.push_back(8'h99); m_cnt = 1; m_held = 8'h99;
        @(negedge clk);
        check("t2b.vld_kept", 32'(rx_vld), 32'(1));
        check("t2b.dat_new", 32'(rx_dat), 32'(8'h99));
        frame_stop();
        check_state("t2b");
        set_rdy(1'b1);

        // Overrun: second byte dropped while first is held.
        set_rdy(1'b0);
        q = {8'h11, 8'h22};
        run_frame("t3", q, 0);
        set_rdy(1'b1);
        pulse_clr();
        check_state("t3.clr");

        // Frame ended mid-byte.
        q = {};
        run_frame("t4", q, 5);
        q = {8'h3C};
        run_frame("t4b", q, 0);
        pulse_clr();
        check_state("t4.clr");

        // Reset in the middle of a byte with ss held low.
        set_rdy(1'b0);
        frame_start();
        send_bits(8'hE0, 3, 1'b0);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_reset();
        fe0 = fe_cnt;
        send_bits(8'h1F, 5, 1'b0);
        send_bits(8'hC3, 8, 1'b0);
        frame_stop();
        check("t5.no_frm_end", 32'(fe_cnt - fe0), 32'(0));
        check_state("t5.rst");
        q = {8'h5A};
        run_frame("t5b", q, 0);

        // sclk activity with ss deasserted is ignored.
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b1; sdi = 1'($urandom); tick();
            sclk = 1'b0; tick();
        end
        repeat (4) tick();
        check_state("t6");
        set_rdy(1'b1);

        // Randomized frames.
        for (int it = 0; it < 24; it++) begin
            int nb, part;
            set_rdy(1'($urandom));
            nb = $urandom_range(1, 4);
            part = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            q = {};
            for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", it), q, part);
            if ($urandom_range(0, 2) == 0) begin
                pulse_clr();
                check_state($sformatf("rnd%0d.clr", it));
            end
        end

        set_rdy(1'b1);
        repeat (3) tick();
        check("end.queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
